// File: rtl/result_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_bus_pkg
// Purpose  : Shared sizing, idle selector code and state encoding for the
//            result bus arbiter.
// Revision : 1.0
// ============================================================================
package result_bus_pkg;

    localparam int NUM_REQ_DEF = 7;
    localparam int DATA_W_DEF  = 32;
    localparam int SEL_W       = 3;

    // Selector code reported while the result register is empty
    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage : result_bus_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating-priority search starting one past the
//            last granted index and wrapping at NUM_REQ-1.
// Revision : 1.0
// ============================================================================
module rr_pick
    import result_bus_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_granted_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [SEL_W-1:0]   grant_idx_o,
    output logic               grant_any_o
);

    int   cand;
    logic found;

    // Walk the candidates in priority order; the first pending one wins
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = SEL_IDLE;
        found       = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_granted_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (cand == j) && req_i[j]) begin
                    grant_oh_o[j] = 1'b1;
                    grant_idx_o   = SEL_W'(j);
                    found         = 1'b1;
                end
            end
        end
        grant_any_o = found;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/result_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : result_bus_arbiter
// Purpose  : Round-robin arbiter feeding a single registered result slot with
//            valid/ready backpressure and same-cycle drain/refill.
// Revision : 1.0
// ============================================================================
module result_bus_arbiter
    import result_bus_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic [SEL_W-1:0]    last_q,  last_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [SEL_W-1:0]    pick_idx;
    logic                pick_any;
    logic                can_accept;
    logic [DATA_W-1:0]   pick_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i          (req),
        .last_granted_i (last_q),
        .grant_oh_o     (pick_oh),
        .grant_idx_o    (pick_idx),
        .grant_any_o    (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_data = pick_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        can_accept = (state_q == ST_EMPTY) || out_ready;
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        last_d     = last_q;
        gnt        = '0;

        if (can_accept && pick_any) begin
            gnt     = pick_oh;
            state_d = ST_FULL;
            data_d  = pick_data;
            sel_d   = pick_idx;
            last_d  = pick_idx;
        end else if (can_accept) begin
            // Drained with nothing to refill: clear so idle outputs read zero/SEL_IDLE
            state_d = ST_EMPTY;
            data_d  = '0;
            sel_d   = SEL_IDLE;
        end

        if (!rst_n) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= SEL_IDLE;
            last_q  <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule : result_bus_arbiter
`default_nettype wire

// File: tb/tb_result_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bus_arbiter
// Purpose  : Directed, table-driven self-checking bench for result_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_result_bus_arbiter;

    localparam int N = 7;
    localparam int W = 32;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [2:0]       out_sel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         rst;
        logic [N-1:0] req;
        logic [W-1:0] seed;
        logic         rdy;
        logic [N-1:0] gnt;
        logic         valid;
        logic [2:0]   sel;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs [15];

    result_bus_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [W-1:0] seed);
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = seed + W'(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_valid", W'(out_valid), 32'd0);
        chk("reset_sel",   W'(out_sel),   32'd7);
        chk("reset_data",  out_data,      32'd0);
    endtask

    // Drive on the falling edge, check gnt mid-low phase, check outputs after the edge
    task automatic apply(input vec_t v, input string tag);
        if (v.rst) do_reset();
        @(negedge clk);
        req       = v.req;
        out_ready = v.rdy;
        set_data(v.seed);
        #1;
        chk({tag, "_gnt"}, W'(gnt), W'(v.gnt));
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, W'(out_valid), W'(v.valid));
        chk({tag, "_sel"},   W'(out_sel),   W'(v.sel));
        chk({tag, "_data"},  out_data,      v.data);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        req_data  = '0;

        //           rst   req         seed          rdy   gnt         v     sel   data
        vecs[0]  = '{1'b1, 7'b0000001, 32'hDEADBEEF, 1'b1, 7'b0000001, 1'b1, 3'd0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 7'b0000000, 32'h0,        1'b1, 7'b0000000, 1'b0, 3'd7, 32'h0};
        vecs[2]  = '{1'b1, 7'b1111111, 32'h10000000, 1'b1, 7'b0000001, 1'b1, 3'd0, 32'h10000000};
        vecs[3]  = '{1'b0, 7'b1111111, 32'h10000000, 1'b1, 7'b0000010, 1'b1, 3'd1, 32'h10000001};
        vecs[4]  = '{1'b0, 7'b1111111, 32'h10000000, 1'b1, 7'b0000100, 1'b1, 3'd2, 32'h10000002};
        vecs[5]  = '{1'b0, 7'b1111111, 32'h10000000, 1'b1, 7'b0001000, 1'b1, 3'd3, 32'h10000003};
        vecs[6]  = '{1'b0, 7'b1111111, 32'h10000000, 1'b1, 7'b0010000, 1'b1, 3'd4, 32'h10000004};
        vecs[7]  = '{1'b0, 7'b1111111, 32'h10000000, 1'b1, 7'b0100000, 1'b1, 3'd5, 32'h10000005};
        vecs[8]  = '{1'b0, 7'b1111111, 32'h10000000, 1'b1, 7'b1000000, 1'b1, 3'd6, 32'h10000006};
        vecs[9]  = '{1'b0, 7'b1111111, 32'h10000000, 1'b1, 7'b0000001, 1'b1, 3'd0, 32'h10000000};
        vecs[10] = '{1'b0, 7'b1000000, 32'h20000000, 1'b1, 7'b1000000, 1'b1, 3'd6, 32'h20000006};
        vecs[11] = '{1'b0, 7'b1000001, 32'h30000000, 1'b1, 7'b0000001, 1'b1, 3'd0, 32'h30000000};
        vecs[12] = '{1'b0, 7'b0010100, 32'h30000000, 1'b1, 7'b0000100, 1'b1, 3'd2, 32'h30000002};
        vecs[13] = '{1'b0, 7'b0010001, 32'h30000000, 1'b1, 7'b0010000, 1'b1, 3'd4, 32'h30000004};
        vecs[14] = '{1'b0, 7'b1111111, 32'h50000000, 1'b0, 7'b0000000, 1'b1, 3'd4, 32'h30000004};

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: slot stays full, requester 6 waits, then wins as soon as ready rises
        for (int c = 0; c < 5; c++) begin
            apply('{1'b0, 7'b1000000, 32'h60000000, 1'b0, 7'b0000000, 1'b1, 3'd4, 32'h30000004},
                  $sformatf("stall%0d", c));
        end
        apply('{1'b0, 7'b1000000, 32'h60000000, 1'b1, 7'b1000000, 1'b1, 3'd6, 32'h60000006}, "release");

        // Asynchronous reset while full, checked well away from any clock edge
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", W'(out_valid), 32'd0);
        chk("async_sel",   W'(out_sel),   32'd7);
        chk("async_data",  out_data,      32'd0);
        chk("async_gnt",   W'(gnt),       32'd0);
        repeat (2) @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("noreplay_valid", W'(out_valid), 32'd0);
        apply('{1'b0, 7'b0000110, 32'h70000000, 1'b1, 7'b0000010, 1'b1, 3'd1, 32'h70000001}, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_result_bus_arbiter
`default_nettype wire

// File: doc/result_bus_arbiter.md
RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 7, number of result requesters.
REQ-002 SHALL have parameter DATA_W, default 32, result width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester result-pending flags; bit i held high until gnt[i] is seen.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_W  flattened results; slice i = bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot acceptance pulse, at most one bit high per cycle.
REQ-008 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result this cycle when out_valid is high.
REQ-010 SHALL have port out_data  output  DATA_W  registered result.
REQ-011 SHALL have port out_sel  output  3  binary index of the requester whose result is in out_data.

Function
REQ-012 SHALL operate as a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL be able to accept when state is EMPTY, or when state is FULL and out_ready=1 (drain and refill in the same cycle).
REQ-014 SHALL, when it can accept and any req bit is high, pick one requester by round-robin, pulse gnt for that index combinationally in the same cycle, and load req_data slice, index and out_valid=1 on the next edge.
REQ-015 SHALL give one-cycle latency from gnt[i] to out_data, out_sel and out_valid.
REQ-016 SHALL start the round-robin search at index (last_granted+1) mod NUM_REQ and wrap from NUM_REQ-1 to 0.
REQ-017 SHALL update the last_granted pointer only on a cycle in which gnt is non-zero.
REQ-018 SHALL keep gnt at all zeros while FULL and out_ready=0, and hold out_data and out_sel stable (backpressure).
REQ-019 SHALL, in state FULL with out_ready=1 and no req, move to EMPTY on the next edge.
REQ-020 SHALL drive out_data to all zeros and out_sel to 3'b111 (SEL_IDLE) whenever out_valid=0.
REQ-021 SHALL ignore req bits while it is unable to accept. A held request SHALL still win within NUM_REQ grants, so there is no starvation.
REQ-022 SHALL ensure gnt never asserts for an index whose req bit is low.

Reset
REQ-023 SHALL, on rst_n low, asynchronously set state EMPTY, out_valid=0, out_data=0, out_sel=3'b111 and last_granted=NUM_REQ-1, so that index 0 has highest priority first.
REQ-024 SHALL force gnt to zero while rst_n is low. A result held at reset SHALL be discarded and not replayed.

Structure
REQ-025 SHALL take NUM_REQ, DATA_W, SEL_IDLE=3'b111 and the state encoding from shared package result_bus_pkg.
REQ-026 SHALL place the rotating-priority search in one combinational sub-module rr_pick. Inputs: req, last_granted. Outputs: one-hot grant and binary index.
REQ-027 SHALL contain no other sub-modules. The expected size is 120-400 lines of RTL.

Verification
REQ-028 SHALL cover: reset, then req=7'b0000001 with slice0=32'hDEADBEEF and out_ready=1 -> gnt=7'b0000001 that cycle; next cycle out_valid=1, out_sel=0, out_data=32'hDEADBEEF.
REQ-029 SHALL cover: all seven req held high with out_ready=1 for 8 cycles -> gnt order 0,1,2,3,4,5,6,0 with one grant per cycle.
REQ-030 SHALL cover: FULL with out_ready=0 for 5 cycles while req=7'b1000000 -> gnt=0 and out_data/out_sel unchanged; out_ready=1 -> gnt=7'b1000000 in that same cycle.
REQ-031 SHALL cover: last grant=6 and req=7'b1000001 -> next grant is index 0 (wrap).
REQ-032 SHALL cover: rst_n dropped while FULL -> out_valid=0, out_sel=3'b111 and out_data=0 immediately, without waiting for a clock edge; after release, req=7'b0000110 -> grant to index 1.
REQ-033 SHALL cover: FULL, out_ready=1, req=0 -> next cycle out_valid=0, out_data=0, out_sel=3'b111.
